rdata_tx_state_machine: RTL and testbench

Slave-side serial transmitter for the bus read-data return path. It returns a DATA_WIDTH-bit read word to the master over a single serial line, LSB first. It uses the same valid/ready handshake the master uses to send addresses to the slave, so the master-side receiver can reuse the same sampling rule. The 5-bit state code drives a bin27 7-segment display, matching the existing transmitter and receiver.

---
 rtl/rdata_tx_state_machine.sv | 89 ++++++++
 tb/tb_rdata_tx_state_machine.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rdata_tx_state_machine.sv
// rdata_tx_state_machine: serialises a read word LSB first over a valid/ready handshake,
// with an optional ready-low timeout that aborts the word.
module rdata_tx_state_machine #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] datain,
    input  logic                  ready,
    output logic                  tx_data,
    output logic                  valid,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [4:0]            state_out
);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2, ERROR = 2'd3} state_e;

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [WW-1:0]         wait_cnt_q, wait_cnt_d;
    logic                  tx_q, valid_q, busy_q, done_q, error_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d    = SEND;
                shift_d    = datain;
                bit_cnt_d  = '0;
                wait_cnt_d = '0;
            end
            SEND: if (ready) begin
                shift_d    = shift_q >> 1;
                bit_cnt_d  = bit_cnt_q + BW'(1);
                wait_cnt_d = '0;
                state_d    = (bit_cnt_q == LAST_BIT) ? DONE : SEND;
            end else if (TIMEOUT != 0) begin
                // a zero TIMEOUT freezes the counter so an endless stall never wraps it
                wait_cnt_d = wait_cnt_q + WW'(1);
                state_d    = (wait_cnt_q == LAST_WAIT) ? ERROR : SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs are registered from the next state so they carry no path from ready or start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            tx_q       <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            tx_q       <= (state_d == SEND) && shift_d[0];
            valid_q    <= state_d == SEND;
            busy_q     <= state_d != IDLE;
            done_q     <= state_d == DONE;
            error_q    <= state_d == ERROR;
        end
    end

    assign tx_data   = tx_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign state_out = {3'b000, state_q};
endmodule

// File: tb/tb_rdata_tx_state_machine.sv
// tb_rdata_tx_state_machine: table of words with ready-stall patterns, a bit scoreboard,
// and hand sequences for timeout, async reset, held start and a 12-bit no-timeout instance.
module tb_rdata_tx_state_machine;
    logic       clk, reset, start, ready;
    logic [7:0] din;
    logic       tx_data, valid, busy, done, error;
    logic [4:0] state_out;
    logic        start12, ready12;
    logic [11:0] din12;
    logic        tx12, valid12, busy12, done12, error12;
    logic [4:0]  state12;

    rdata_tx_state_machine #(.DATA_WIDTH(8), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .start(start), .datain(din), .ready(ready),
        .tx_data(tx_data), .valid(valid), .busy(busy), .done(done), .error(error),
        .state_out(state_out));

    rdata_tx_state_machine #(.DATA_WIDTH(12), .TIMEOUT(0)) dut12 (
        .clk(clk), .reset(reset), .start(start12), .datain(din12), .ready(ready12),
        .tx_data(tx12), .valid(valid12), .busy(busy12), .done(done12), .error(error12),
        .state_out(state12));

    typedef struct {
        logic [7:0] d;
        int         sa;
        int         sl;
        int         lat;
    } vec_t;

    int   vec = 0, errs = 0;
    int   done_cnt = 0, err_cnt = 0, err12_cnt = 0;
    logic q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        done_cnt  += int'(done);
        err_cnt   += int'(error);
        err12_cnt += int'(error12);
        if (reset && valid && ready) begin
            if (q.size() == 0) begin
                vec++;
                errs++;
                $display("FAIL sb_extra: transfer of %0b seen, none expected", tx_data);
            end else chk("sb_bit", tx_data, q.pop_front());
        end
    end

    task automatic run_word(input logic [7:0] d, input int sa, input int sl, input int lat);
        int n, xf, st, dc, ec;
        bit fin;
        dc = done_cnt;
        ec = err_cnt;
        @(posedge clk); #1;
        din = d; start = 1'b1; ready = 1'b1;
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        @(posedge clk); #1;
        start = 1'b0; din = ~d;
        n = 1; xf = 0; st = 0; fin = 0;
        while (!fin && n <= 40) begin
            ready = !(xf == sa && st < sl);
            @(negedge clk);
            if (done) fin = 1;
            else begin
                chk("send_valid", valid, 1);
                chk("send_state", state_out, 1);
                if (!ready) begin
                    chk("stall_hold", tx_data, d[xf]);
                    st++;
                end else xf++;
                @(posedge clk); #1;
                n++;
            end
        end
        chk("done_latency", n, lat);
        chk("done_state", state_out, 2);
        chk("done_valid", valid, 0);
        chk("done_busy", busy, 1);
        @(negedge clk);
        chk("idle_state", state_out, 0);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("sb_drain", q.size(), 0);
        chk("no_error", err_cnt, ec);
        chk("one_done", done_cnt, dc + 1);
        ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   n, k, dc, ec;
        logic [11:0] d12;
        tbl[0] = '{8'hA5, 8, 0, 9};
        tbl[1] = '{8'h3C, 2, 3, 12};
        tbl[2] = '{8'hFF, 8, 0, 9};
        tbl[3] = '{8'h01, 7, 5, 14};
        tbl[4] = '{8'h80, 0, 14, 23};
        tbl[5] = '{8'h5A, 4, 1, 10};
        reset = 1'b1; start = 1'b0; ready = 1'b0; din = '0;
        start12 = 1'b0; ready12 = 1'b0; din12 = '0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_tx", tx_data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_state", state_out, 0);
        @(posedge clk); #1 reset = 1'b1;

        for (int i = 0; i < 6; i++) run_word(tbl[i].d, tbl[i].sa, tbl[i].sl, tbl[i].lat);

        // timeout: ready never rises
        dc = done_cnt; ec = err_cnt;
        @(posedge clk); #1 din = 8'h96; start = 1'b1; ready = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (!valid) break;
            n++;
            @(posedge clk); #1;
        end
        chk("to_valid_cycles", n, 15);
        chk("to_error", error, 1);
        chk("to_state", state_out, 3);
        @(negedge clk);
        chk("to_idle_state", state_out, 0);
        chk("to_error_once", error, 0);
        chk("to_err_cnt", err_cnt, ec + 1);
        chk("to_no_done", done_cnt, dc);
        ready = 1'b1;

        // async reset after 4 of 8 bits
        dc = done_cnt; ec = err_cnt;
        @(posedge clk); #1 din = 8'hF0; start = 1'b1;
        for (int i = 0; i < 8; i++) q.push_back(din[i]);
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("mid_tx_pre", tx_data, 1);
        chk("mid_valid_pre", valid, 1);
        reset = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tx", tx_data, 0);
        chk("arst_state", state_out, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        chk("arst_no_done", done_cnt, dc);
        chk("arst_no_error", err_cnt, ec);
        run_word(8'hFF, 8, 0, 9);

        // start held high with datain changing every cycle
        dc = done_cnt;
        ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            start = 1'b1;
            din = 8'(c * 37 + 5);
            if (c % 10 == 0)
                for (int i = 0; i < 8; i++) q.push_back(din[i]);
            @(negedge clk);
            if (c == 10 || c == 20) chk("held_gap_idle", state_out, 0);
        end
        @(posedge clk); #1 start = 1'b0;
        repeat (12) @(posedge clk);
        chk("held_done_cnt", done_cnt, dc + 3);
        chk("held_drain", q.size(), 0);

        // 12-bit, no timeout, ready toggling
        d12 = 12'h801;
        @(posedge clk); #1 din12 = d12; start12 = 1'b1;
        @(posedge clk); #1 start12 = 1'b0; din12 = '0;
        n = 0; k = 0;
        while (n < 60) begin
            ready12 = (n % 2 == 0);
            @(negedge clk);
            if (done12) break;
            if (ready12 && valid12) begin
                chk("w12_bit", tx12, d12[k]);
                k++;
            end
            n++;
            @(posedge clk); #1;
        end
        chk("w12_cycles", n, 23);
        chk("w12_bits", k, 12);
        @(negedge clk);
        chk("w12_done_once", done12, 0);
        chk("w12_idle", state12, 0);
        // an endless stall must not abort when the timeout is disabled
        @(posedge clk); #1 din12 = 12'hFFF; start12 = 1'b1; ready12 = 1'b0;
        @(posedge clk); #1 start12 = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("w12_long_stall_valid", valid12, 1);
        ready12 = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        chk("w12_stall_done_state", state12, 0);
        chk("w12_no_error", err12_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
